// File: rtl/cache_lru_repl_pkg.sv
// Shared cache replacement types and constants: per-cache geometry, index/age
// typedefs and the reset age of a way.
package cache_lru_repl_pkg;

  // Index width with a floor of one bit, so one-set or one-way configs still have a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DCACHE_NUM_SETS = 4;
  localparam int DCACHE_NUM_WAYS = 4;
  localparam int ICACHE_NUM_SETS = 8;
  localparam int ICACHE_NUM_WAYS = 2;

  localparam int LRU_NUM_SETS = DCACHE_NUM_SETS;
  localparam int LRU_NUM_WAYS = DCACHE_NUM_WAYS;
  localparam int LRU_SET_W    = idx_width(LRU_NUM_SETS);
  localparam int LRU_WAY_W    = idx_width(LRU_NUM_WAYS);

  typedef logic [LRU_WAY_W-1:0] way_idx_t;
  typedef logic [LRU_SET_W-1:0] set_idx_t;
  typedef logic [LRU_WAY_W-1:0] lru_age_t;

  function automatic int unsigned lru_age_reset(input int unsigned way);
    return way;
  endfunction

endpackage

// File: rtl/cache_lru_repl_set_age.sv
// One set's LRU age vector (0 = MRU, NUM_WAYS-1 = LRU). Applies a same-cycle
// update (promote to MRU) followed by an invalidate (demote to LRU).
module lru_set_age
  import cache_lru_repl_pkg::*;
#(
  parameter  int NUM_WAYS = 4,
  localparam int WAY_W    = idx_width(NUM_WAYS)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               upd_en,
  input  logic [WAY_W-1:0]                   upd_way,
  input  logic                               inv_en,
  input  logic [WAY_W-1:0]                   inv_way,
  output logic [NUM_WAYS-1:0][WAY_W-1:0]     age_o
);

  logic [NUM_WAYS-1:0][WAY_W-1:0] age_q, age_d, age_mid;
  logic [WAY_W-1:0]               upd_age, inv_age;
  logic                           upd_ok, inv_ok;
  logic [(1<<WAY_W)-1:0]          seen;
  logic                           perm_ok;

  always_comb begin
    upd_age = '0;
    upd_ok  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == upd_way) begin
        upd_age = age_q[w];
        upd_ok  = upd_en;
      end
    end

    age_mid = age_q;
    if (upd_ok) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == upd_way)    age_mid[w] = '0;
        else if (age_q[w] < upd_age) age_mid[w] = age_q[w] + WAY_W'(1);
      end
    end

    // Invalidate sees the post-update vector so update-then-invalidate of one way ends at LRU.
    inv_age = '0;
    inv_ok  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == inv_way) begin
        inv_age = age_mid[w];
        inv_ok  = inv_en;
      end
    end

    age_d = age_mid;
    if (inv_ok) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == inv_way)      age_d[w] = WAY_W'(NUM_WAYS - 1);
        else if (age_mid[w] > inv_age) age_d[w] = age_mid[w] - WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WAYS; w++) age_q[w] <= WAY_W'(lru_age_reset(w));
    end else begin
      age_q <= age_d;
    end
  end

  assign age_o = age_q;

  // NUM_WAYS entries covering every value 0..NUM_WAYS-1 is exactly a permutation.
  always_comb begin
    seen = '0;
    for (int w = 0; w < NUM_WAYS; w++) seen[age_q[w]] = 1'b1;
    perm_ok = 1'b1;
    for (int v = 0; v < NUM_WAYS; v++) if (!seen[v]) perm_ok = 1'b0;
  end

  a_age_permutation: assert property (@(posedge clock) disable iff (!reset) perm_ok);

endmodule

// File: rtl/cache_lru_repl.sv
// True-LRU replacement controller: per-set age vectors, set decode, victim
// selection (invalid first, else oldest unlocked) and a one-cycle victim response.
module cache_lru_repl
  import cache_lru_repl_pkg::*;
#(
  parameter  int NUM_SETS = 4,
  parameter  int NUM_WAYS = 4,
  localparam int SET_W    = idx_width(NUM_SETS),
  localparam int WAY_W    = idx_width(NUM_WAYS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                victim_req,
  input  logic [SET_W-1:0]    victim_set,
  input  logic [NUM_WAYS-1:0] valid_mask,
  input  logic [NUM_WAYS-1:0] lock_mask,
  output logic                victim_valid,
  output logic [WAY_W-1:0]    victim_way,
  output logic                victim_none,
  input  logic                update_req,
  input  logic [SET_W-1:0]    update_set,
  input  logic [WAY_W-1:0]    update_way,
  input  logic                inval_req,
  input  logic [SET_W-1:0]    inval_set,
  input  logic [WAY_W-1:0]    inval_way
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] set_age;

  // Out-of-range set indices match no instance, so their updates/invalidates vanish.
  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    logic upd_hit, inv_hit;
    assign upd_hit = update_req && (update_set == SET_W'(s));
    assign inv_hit = inval_req  && (inval_set  == SET_W'(s));

    lru_set_age #(.NUM_WAYS(NUM_WAYS)) u_set_age (
      .clock   (clock),
      .reset   (reset),
      .upd_en  (upd_hit),
      .upd_way (update_way),
      .inv_en  (inv_hit),
      .inv_way (inval_way),
      .age_o   (set_age[s])
    );
  end

  logic [NUM_WAYS-1:0][WAY_W-1:0] sel_age;
  logic                           in_range;
  logic                           found_inv, any_cand;
  logic [WAY_W-1:0]               inv_pick, age_pick, best_age;
  logic                           victim_valid_d, victim_valid_q;
  logic [WAY_W-1:0]               victim_way_d, victim_way_q;
  logic                           victim_none_d, victim_none_q;

  always_comb begin
    sel_age  = '0;
    in_range = 1'b0;
    for (int s = 0; s < NUM_SETS; s++) begin
      if (victim_set == SET_W'(s)) begin
        sel_age  = set_age[s];
        in_range = 1'b1;
      end
    end

    found_inv = 1'b0;
    any_cand  = 1'b0;
    inv_pick  = '0;
    age_pick  = '0;
    best_age  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!lock_mask[w]) begin
        if (!valid_mask[w] && !found_inv) begin
          found_inv = 1'b1;
          inv_pick  = WAY_W'(w);
        end
        if (!any_cand || (sel_age[w] > best_age)) begin
          best_age = sel_age[w];
          age_pick = WAY_W'(w);
        end
        any_cand = 1'b1;
      end
    end

    victim_valid_d = victim_req;
    victim_none_d  = 1'b0;
    victim_way_d   = '0;
    if (victim_req) begin
      if (!in_range || !any_cand) victim_none_d = 1'b1;
      else if (found_inv)         victim_way_d  = inv_pick;
      else                        victim_way_d  = age_pick;
    end
  end

  // Response register: victim search result appears one cycle after the request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_none_q  <= 1'b0;
    end else begin
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      victim_none_q  <= victim_none_d;
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;
  assign victim_none  = victim_none_q;

endmodule

// File: tb/tb_cache_lru_repl.sv
// Bench for cache_lru_repl (3 sets x 4 ways): recency-list model checked every
// cycle, plus directed vectors with literal expected victims.
module tb_cache_lru_repl;

  localparam int NS = 3;
  localparam int NW = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       victim_req = 1'b0;
  logic [1:0] victim_set = '0;
  logic [3:0] valid_mask = '0;
  logic [3:0] lock_mask = '0;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic       victim_none;
  logic       update_req = 1'b0;
  logic [1:0] update_set = '0;
  logic [1:0] update_way = '0;
  logic       inval_req = 1'b0;
  logic [1:0] inval_set = '0;
  logic [1:0] inval_way = '0;

  int n_checks = 0;
  int n_pass   = 0;

  cache_lru_repl #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clock        (clock),
    .reset        (reset),
    .victim_req   (victim_req),
    .victim_set   (victim_set),
    .valid_mask   (valid_mask),
    .lock_mask    (lock_mask),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .victim_none  (victim_none),
    .update_req   (update_req),
    .update_set   (update_set),
    .update_way   (update_way),
    .inval_req    (inval_req),
    .inval_set    (inval_set),
    .inval_way    (inval_way)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: each set is a recency list, front = most recently used, back = LRU.
  int lst [NS][$];
  int exp_valid = 0;
  int exp_way   = 0;
  int exp_none  = 0;

  function automatic int pos_of(input int s, input int w);
    for (int i = 0; i < lst[s].size(); i++) if (lst[s][i] == w) return i;
    return -1;
  endfunction

  task automatic move_way(input int s, input int w, input bit to_front);
    int p;
    p = pos_of(s, w);
    if (p >= 0) lst[s].delete(p);
    if (to_front) lst[s].push_front(w);
    else          lst[s].push_back(w);
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NS; s++) begin
        lst[s].delete();
        for (int w = 0; w < NW; w++) lst[s].push_back(w);
      end
      exp_valid = 0;
      exp_way   = 0;
      exp_none  = 0;
    end else begin
      exp_valid = victim_req ? 1 : 0;
      exp_way   = 0;
      exp_none  = 0;
      if (victim_req) begin
        if (int'(victim_set) >= NS) begin
          exp_none = 1;
        end else begin
          int inv_w, old_w, old_p;
          inv_w = -1;
          old_w = -1;
          old_p = -1;
          for (int w = 0; w < NW; w++) begin
            if (!lock_mask[w]) begin
              if (!valid_mask[w] && inv_w < 0) inv_w = w;
              if (pos_of(int'(victim_set), w) > old_p) begin
                old_p = pos_of(int'(victim_set), w);
                old_w = w;
              end
            end
          end
          if (old_w < 0)      exp_none = 1;
          else if (inv_w >= 0) exp_way = inv_w;
          else                 exp_way = old_w;
        end
      end
      if (update_req && int'(update_set) < NS) move_way(int'(update_set), int'(update_way), 1'b1);
      if (inval_req  && int'(inval_set)  < NS) move_way(int'(inval_set),  int'(inval_way),  1'b0);
    end
  end

  always @(negedge clock) begin
    chk("cyc_valid", int'(victim_valid), exp_valid);
    chk("cyc_way",   int'(victim_way),   exp_way);
    chk("cyc_none",  int'(victim_none),  exp_none);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    victim_req = 1'b0; update_req = 1'b0; inval_req = 1'b0;
    victim_set = '0; valid_mask = '0; lock_mask = '0;
    update_set = '0; update_way = '0; inval_set = '0; inval_way = '0;
  endtask

  task automatic vreq(input logic [1:0] s, input logic [3:0] vm, input logic [3:0] lm);
    victim_req = 1'b1; victim_set = s; valid_mask = vm; lock_mask = lm;
  endtask

  task automatic upd(input logic [1:0] s, input logic [1:0] w);
    update_req = 1'b1; update_set = s; update_way = w;
  endtask

  task automatic inv(input logic [1:0] s, input logic [1:0] w);
    inval_req = 1'b1; inval_set = s; inval_way = w;
  endtask

  // Literal expectation for a victim response, also pinning the model to it.
  task automatic lit(input string name, input int way, input int none);
    chk({name, "_valid"},      int'(victim_valid), 1);
    chk({name, "_way"},        int'(victim_way),   way);
    chk({name, "_none"},       int'(victim_none),  none);
    chk({name, "_model_way"},  exp_way,            way);
    chk({name, "_model_none"}, exp_none,           none);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) cyc();
    chk("reset_valid", int'(victim_valid), 0);
    chk("reset_way",   int'(victim_way),   0);
    reset = 1'b1;
    cyc();

    vreq(2'd0, 4'hF, 4'h0); cyc(); idle();
    lit("fresh_set0", 3, 0);

    for (int w = 3; w >= 0; w--) begin
      upd(2'd1, 2'(w)); cyc(); idle();
    end
    vreq(2'd1, 4'hF, 4'h0); cyc(); idle();
    lit("set1_after_3210", 3, 0);
    upd(2'd1, 2'd3); cyc(); idle();
    vreq(2'd1, 4'hF, 4'h0); cyc(); idle();
    lit("set1_after_mru3", 2, 0);

    vreq(2'd0, 4'b1010, 4'h0); cyc(); idle();
    lit("invalid_first", 0, 0);
    vreq(2'd0, 4'b1010, 4'b0001); cyc(); idle();
    lit("invalid_locked", 2, 0);

    vreq(2'd0, 4'hF, 4'hF); cyc(); idle();
    lit("all_locked", 0, 1);
    vreq(2'd3, 4'hF, 4'h0); cyc(); idle();
    lit("set_out_of_range", 0, 1);
    upd(2'd3, 2'd3); inv(2'd3, 2'd0); cyc(); idle();
    vreq(2'd0, 4'hF, 4'h0); cyc(); idle();
    lit("oor_upd_ignored", 3, 0);

    upd(2'd2, 2'd1); inv(2'd2, 2'd1); vreq(2'd2, 4'hF, 4'h0); cyc(); idle();
    lit("same_cycle_pre", 3, 0);
    vreq(2'd2, 4'hF, 4'h0); cyc(); idle();
    lit("upd_inv_same_way", 1, 0);

    vreq(2'd1, 4'hF, 4'h0); cyc();
    lit("pre_reset", 2, 0);
    #2 reset = 1'b0;
    #1 chk("reset_async_valid", int'(victim_valid), 0);
    cyc();
    chk("reset_pending_valid", int'(victim_valid), 0);
    reset = 1'b1;
    idle();
    vreq(2'd1, 4'hF, 4'h0); cyc(); idle();
    lit("post_reset_set1", 3, 0);
    vreq(2'd2, 4'hF, 4'h0); cyc(); idle();
    lit("post_reset_set2", 3, 0);
    vreq(2'd1, 4'hF, 4'b1000); cyc(); idle();
    lit("post_reset_lock3", 2, 0);

    for (int i = 0; i < 400; i++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        vreq(2'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
             ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
      if ($urandom_range(0, 2) != 0) upd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) inv(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      cyc();
    end
    idle();
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
